// File: rtl/approx_mul_pkg.sv
// Shared types for the approximate half-adder multiplier: cell modes and the
// single-cell behaviour used by every HA array.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    HA_EXACT  = 2'b00,
    HA_OR     = 2'b01,
    HA_ACARRY = 2'b10,
    HA_ELIM   = 2'b11
  } ha_mode_e;

  // Returns {carry, sum} of one half-adder cell under the given mode.
  function automatic logic [1:0] ha_cell(input ha_mode_e mode, input logic a, input logic b);
    logic [1:0] cs;
    case (mode)
      HA_EXACT:  cs = {a & b, a ^ b};
      HA_OR:     cs = {1'b0, a | b};
      HA_ACARRY: cs = {a, 1'b0};
      default:   cs = 2'b00;
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/approx_ha_row.sv
// One HA array: folds partial-product rows 2k and 2k+1 into a sum vector t and
// a carry vector b, each cell running in its own approximation mode.
module approx_ha_row
  import approx_mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [1:0]         x_pair,
  input  logic [N-1:0]       y,
  input  logic [2*(N-1)-1:0] modes,
  output logic [N:0]         t,
  output logic [N-2:0]       b
);

  logic [N-2:0] s_v;
  logic [N-2:0] c_v;

  // Cell j adds pp[2k][j+1] and pp[2k+1][j], both at weight j+1.
  for (genvar j = 0; j < N - 1; j++) begin : g_cell
    assign {c_v[j], s_v[j]} = ha_cell(ha_mode_e'(modes[2*j +: 2]),
                                      x_pair[0] & y[j+1],
                                      x_pair[1] & y[j]);
  end

  assign t = {c_v[N-2], s_v, x_pair[0] & y[0]};
  assign b = {x_pair[1] & y[N-1], c_v[N-3:0]};

endmodule

// File: rtl/approx_ha_mul_pipe.sv
// Three-stage elastic approximate NxN multiplier: operand register, HA-array
// register, final-sum register; per-array mode table writable only when empty.
module approx_ha_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter  int N     = 8,
  localparam int ROWS  = N / 2,
  localparam int CELLS = N - 1,
  localparam int RW    = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       x,
  input  logic [N-1:0]       y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N-1:0]     p,
  input  logic               cfg_we,
  input  logic [RW-1:0]      cfg_row,
  input  logic [2*CELLS-1:0] cfg_data,
  output logic               cfg_ready
);

  logic               v1, v2, v3;
  logic               ld1, ld2, ld3;
  logic               cfg_take, row_ok, accept;
  logic [N-1:0]       x_q, y_q;
  logic [N:0]         t_d [ROWS];
  logic [N:0]         t_q [ROWS];
  logic [N-2:0]       b_d [ROWS];
  logic [N-2:0]       b_q [ROWS];
  logic [2*CELLS-1:0] mode_tbl [ROWS];
  logic [2*N-1:0]     p_d;

  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign cfg_ready = !(v1 || v2 || v3);
  assign cfg_take  = cfg_we && cfg_ready;
  assign in_ready  = ld1 && !cfg_take;
  assign accept    = in_valid && in_ready;
  assign out_valid = v3;

  if ((1 << RW) == ROWS) begin : g_row_pow2
    assign row_ok = 1'b1;
  end else begin : g_row_chk
    assign row_ok = (32'(cfg_row) < ROWS);
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_row
    approx_ha_row #(.N(N)) u_row (
      .x_pair (x_q[2*k +: 2]),
      .y      (y_q),
      .modes  (mode_tbl[k]),
      .t      (t_d[k]),
      .b      (b_d[k])
    );
  end

  // Carries in b sit two bits above their index within the array.
  always_comb begin
    p_d = '0;
    for (int k = 0; k < ROWS; k++) begin
      p_d = p_d + ((((2*N)'(t_q[k])) + (((2*N)'(b_q[k])) << 2)) << (2 * k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      p   <= '0;
      for (int k = 0; k < ROWS; k++) begin
        t_q[k]      <= '0;
        b_q[k]      <= '0;
        mode_tbl[k] <= {CELLS{HA_EXACT}};
      end
    end else begin
      if (ld1) begin
        v1 <= accept;
        if (accept) begin
          x_q <= x;
          y_q <= y;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          for (int k = 0; k < ROWS; k++) begin
            t_q[k] <= t_d[k];
            b_q[k] <= b_d[k];
          end
        end
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) p <= p_d;
      end
      if (cfg_take && row_ok) mode_tbl[cfg_row] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_approx_ha_mul_pipe.sv
// Directed bench for approx_ha_mul_pipe: latency, exact sweep, cell modes,
// back-pressure, config/pipeline interlock and mid-stream reset.
module tb_approx_ha_mul_pipe;

  localparam int N     = 8;
  localparam int CELLS = N - 1;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       x;
  logic [N-1:0]       y;
  logic               out_valid;
  logic               out_ready;
  logic [2*N-1:0]     p;
  logic               cfg_we;
  logic [1:0]         cfg_row;
  logic [2*CELLS-1:0] cfg_data;
  logic               cfg_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_p     = '0;

  logic [7:0]  sx[5] = '{8'd12, 8'd200, 8'd255, 8'd7, 8'd100};
  logic [7:0]  sy[5] = '{8'd13, 8'd3, 8'd2, 8'd9, 8'd100};
  logic [31:0] se[5] = '{32'd156, 32'd600, 32'd510, 32'd63, 32'd10000};

  approx_ha_mul_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .cfg_we    (cfg_we),
    .cfg_row   (cfg_row),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_p", p, prev_p);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_val("out_extra", exp_q.size(), 1);
        else check_val("product", p, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = p;
    end
  end

  task automatic send(input logic [N-1:0] xv, input logic [N-1:0] yv, input logic [31:0] e);
    bit taken;
    taken    = 0;
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        taken = 1;
      end
    end
    if (!taken) begin
      check_val("send_timeout", in_ready, 1);
      in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] row, input logic [2*CELLS-1:0] d);
    bit taken;
    taken    = 0;
    in_valid = 1'b0;
    cfg_we   = 1'b1;
    cfg_row  = row;
    cfg_data = d;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (cfg_ready) taken = 1;
    end
    if (!taken) check_val("cfg_timeout", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done     = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    check_val("drain_q", exp_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_row   = '0;
    cfg_data  = '0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_p", p, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_cfg_ready", cfg_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted before edge 1, visible after edge 3.
    send(8'd255, 8'd255, 32'd65025);
    in_valid = 1'b0;
    @(negedge clk);
    check_val("lat_c1", out_valid, 0);
    @(negedge clk);
    check_val("lat_c2", out_valid, 0);
    @(negedge clk);
    check_val("lat_c3", out_valid, 1);
    @(posedge clk);
    #1;
    drain();

    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++)
        send(8'(i), 8'(j), 32'(i * j));
    drain();

    cfg_write(2'd0, 14'h3FFF);
    send(8'd3, 8'd3, 32'd1);
    drain();
    cfg_write(2'd0, 14'h1555);
    send(8'd3, 8'd3, 32'd7);
    drain();
    cfg_write(2'd0, 14'h0000);
    send(8'd3, 8'd3, 32'd9);
    drain();

    // Back-pressure: out_ready low for five cycles under a back-to-back stream.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(sx[i], sy[i], se[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("stall_in_ready", in_ready, 0);
        check_val("stall_out_valid", out_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Config request with two operands in flight waits; they keep the old table.
    send(8'd3, 8'd3, 32'd9);
    send(8'd5, 8'd6, 32'd30);
    in_valid = 1'b0;
    cfg_we   = 1'b1;
    cfg_row  = 2'd0;
    cfg_data = 14'h1555;
    @(negedge clk);
    check_val("cfg_busy", cfg_ready, 0);
    @(posedge clk);
    #1;
    cfg_write(2'd0, 14'h1555);
    send(8'd3, 8'd3, 32'd7);
    drain();
    cfg_write(2'd0, 14'h0000);

    // Config write and operand offered together on an empty pipeline.
    in_valid = 1'b1;
    x        = 8'd3;
    y        = 8'd3;
    cfg_we   = 1'b1;
    cfg_row  = 2'd0;
    cfg_data = 14'h3FFF;
    @(negedge clk);
    check_val("same_cfg_ready", cfg_ready, 1);
    check_val("same_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    @(negedge clk);
    check_val("same_accept", in_ready, 1);
    if (in_ready) exp_q.push_back(32'd1);
    @(posedge clk);
    #1;
    drain();
    cfg_write(2'd0, 14'h0000);

    // Mid-stream reset with row 1 in OR mode.
    cfg_write(2'd1, 14'h1555);
    send(8'd12, 8'd3, 32'd28);
    send(8'd3, 8'd3, 32'd9);
    send(8'd12, 8'd3, 32'd28);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_cfg_ready", cfg_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'd12, 8'd3, 32'd36);
    send(8'd3, 8'd3, 32'd9);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
